// File: rtl/plru_pkg.sv
// Shared types and tree pseudo-LRU helpers for the per-set replacement-state memory.
// Helpers work on max-width vectors with the real way count passed as an argument.
package plru_pkg;

   localparam int MAX_WAYS = 64;
   localparam int MAX_LVL  = 6;

   typedef enum logic {CLEAR, RUN} clr_state_t;

   typedef logic [MAX_WAYS-2:0] tree_t;
   typedef logic [MAX_WAYS-1:0] vec_t;
   typedef logic [MAX_LVL-1:0]  way_t;

   typedef struct packed {
      logic found;
      way_t way;
   } inv_t;

   function automatic int tree_levels(int nw);
      int lv = 0;
      for (int l = 0; l < MAX_LVL; l++)
         if ((1 << l) < nw) lv++;
      return lv;
   endfunction

   // Follow node bits from the root; each bit picked becomes the next way bit, MSB first.
   function automatic way_t plru_victim(tree_t bits, int nw);
      way_t       w    = '0;
      logic [5:0] node = '0;
      for (int l = 0; l < MAX_LVL; l++) begin
         if (l < tree_levels(nw)) begin
            w    = {w[MAX_LVL-2:0], bits[node]};
            node = {node[4:0], 1'b0} + (bits[node] ? 6'd2 : 6'd1);
         end
      end
      return w;
   endfunction

   function automatic tree_t plru_update(tree_t bits, way_t way, int nw);
      tree_t      t    = bits;
      way_t       wa   = way << (MAX_LVL - tree_levels(nw));
      logic [5:0] node = '0;
      logic       b;
      for (int l = 0; l < MAX_LVL; l++) begin
         if (l < tree_levels(nw)) begin
            b       = wa[MAX_LVL-1];
            t[node] = ~b;
            node    = {node[4:0], 1'b0} + (b ? 6'd2 : 6'd1);
            wa      = wa << 1;
         end
      end
      return t;
   endfunction

   // Scans high to low so the lowest invalid way wins.
   function automatic inv_t first_invalid(vec_t v, int nw);
      inv_t r = '0;
      for (int i = MAX_WAYS - 1; i >= 0; i--) begin
         if (i < nw && !v[i[5:0]]) begin
            r.found = 1'b1;
            r.way   = i[MAX_LVL-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/plru_mem_clear_ctrl.sv
// Post-reset clear walk: zeroes one set per cycle, then raises ready until the next reset.
module plru_clear_ctrl
   import plru_pkg::*;
#(
   parameter int NUM_SETS = 32,
   parameter int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             clr_en,
   output logic [IDX_W-1:0] clr_idx,
   output logic             ready
);

   clr_state_t       state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_en    = 1'b0;
      case (state)
         CLEAR: begin
            clr_en  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == IDX_W'(NUM_SETS - 1)) state_nxt = RUN;
         end
         default: ;
      endcase
   end

   assign clr_idx = cnt;
   assign ready   = (state == RUN);

endmodule

// File: rtl/plru_mem.sv
// Per-set tree-PLRU state for an N-way cache: combinational victim pick (invalid ways first)
// and path update on completed accesses. NUM_WAYS is limited to MAX_WAYS.
module plru_mem
   import plru_pkg::*;
#(
   parameter int NUM_SETS = 32,
   parameter int NUM_WAYS = 4,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    rd_idx,
   input  logic [NUM_WAYS-1:0] valid_vec,
   output logic [WAY_W-1:0]    victim_way,
   output logic                victim_inv,
   input  logic                upd_en,
   input  logic [IDX_W-1:0]    upd_idx,
   input  logic [WAY_W-1:0]    upd_way,
   output logic                ready
);

   localparam int TREE_W = NUM_WAYS - 1;

   logic [TREE_W-1:0] mem [NUM_SETS];
   logic              clr_en;
   logic [IDX_W-1:0]  clr_idx;
   inv_t              fi;

   plru_clear_ctrl #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) u_clr (
      .clk     (clk),
      .rst     (rst),
      .clr_en  (clr_en),
      .clr_idx (clr_idx),
      .ready   (ready)
   );

   // clr_en and ready are mutually exclusive, so updates never race the walk.
   always_ff @(posedge clk) begin
      if (clr_en)
         mem[clr_idx] <= '0;
      else if (ready && upd_en)
         mem[upd_idx] <= TREE_W'(plru_update(tree_t'(mem[upd_idx]), way_t'(upd_way), NUM_WAYS));
   end

   // Reads the stored bits directly: a same-cycle update to rd_idx shows up next cycle.
   always_comb begin
      fi         = first_invalid(vec_t'(valid_vec), NUM_WAYS);
      victim_way = '0;
      victim_inv = 1'b0;
      if (ready) begin
         if (fi.found) begin
            victim_way = WAY_W'(fi.way);
            victim_inv = 1'b1;
         end else begin
            victim_way = WAY_W'(plru_victim(tree_t'(mem[rd_idx]), NUM_WAYS));
         end
      end
   end

endmodule

// File: tb/tb_plru_mem.sv
// Scoreboard bench for plru_mem: a 4-way/32-set instance and a 2-way/4-set instance.
module tb_plru_mem;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rd_idx, upd_idx;
   logic [3:0] valid_vec;
   logic [1:0] victim_way, upd_way;
   logic       victim_inv, upd_en, ready;

   logic [1:0] rd_idx2, upd_idx2, valid2;
   logic [0:0] vway2, upd_way2;
   logic       vinv2, upd_en2, ready2;

   always #5 clk = ~clk;

   plru_mem #(.NUM_SETS(32), .NUM_WAYS(4)) u1 (
      .clk(clk), .rst(rst), .rd_idx(rd_idx), .valid_vec(valid_vec),
      .victim_way(victim_way), .victim_inv(victim_inv), .upd_en(upd_en),
      .upd_idx(upd_idx), .upd_way(upd_way), .ready(ready));

   plru_mem #(.NUM_SETS(4), .NUM_WAYS(2)) u2 (
      .clk(clk), .rst(rst), .rd_idx(rd_idx2), .valid_vec(valid2),
      .victim_way(vway2), .victim_inv(vinv2), .upd_en(upd_en2),
      .upd_idx(upd_idx2), .upd_way(upd_way2), .ready(ready2));

   typedef struct {
      string      name;
      int         dut;
      logic       rdy;
      logic [1:0] way;
      logic       inv;
   } exp_t;

   exp_t q[$];
   logic chk = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Monitor: pops one expectation per flagged cycle, sampling on the falling edge.
   always @(negedge clk) begin
      if (chk) begin
         exp_t       e;
         logic       ar, ai;
         logic [1:0] aw;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: output presented with no expectation queued");
         end else begin
            e = q.pop_front();
            if (e.dut == 1) begin ar = ready;  aw = victim_way;     ai = victim_inv; end
            else            begin ar = ready2; aw = {1'b0, vway2};  ai = vinv2;      end
            if (ar !== e.rdy || aw !== e.way || ai !== e.inv) begin
               errors++;
               $display("FAIL %s: got ready=%b way=%0d inv=%b, expected ready=%b way=%0d inv=%b",
                        e.name, ar, aw, ai, e.rdy, e.way, e.inv);
            end
         end
      end
   end

   task automatic cyc(input string n, input int d, input logic r, input logic [1:0] w, input logic i);
      exp_t e;
      e.name = n; e.dut = d; e.rdy = r; e.way = w; e.inv = i;
      q.push_back(e);
      chk = 1'b1;
      @(negedge clk); #1;
      chk = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rd_idx = '0; valid_vec = '0; upd_en = 1'b0; upd_idx = '0; upd_way = '0;
      rd_idx2 = '0; valid2 = '0; upd_en2 = 1'b0; upd_idx2 = '0; upd_way2 = '0;
      idle();
      cyc("reset_state", 1, 1'b0, 2'd0, 1'b0);
      cyc("reset_state2", 2, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;

      // Walk: ready low for exactly 32 edges; victim gated even with all ways invalid.
      for (int k = 0; k < 32; k++) cyc("clear_walk", 1, 1'b0, 2'd0, 1'b0);
      valid_vec = 4'hF;
      for (int s = 0; s < 32; s++) begin
         rd_idx = 5'(s);
         cyc("cleared_set", 1, 1'b1, 2'd0, 1'b0);
      end

      // PLRU sequence on set 5.
      rd_idx = 5'd5; upd_idx = 5'd5;
      upd_en = 1'b1; upd_way = 2'd0; cyc("acc_w0_pre", 1, 1'b1, 2'd0, 1'b0);
      upd_en = 1'b0;                 cyc("acc_w0",     1, 1'b1, 2'd2, 1'b0);
      upd_en = 1'b1; upd_way = 2'd2; cyc("acc_w2_pre", 1, 1'b1, 2'd2, 1'b0);
      upd_en = 1'b0;                 cyc("acc_w2",     1, 1'b1, 2'd1, 1'b0);
      upd_en = 1'b1; upd_way = 2'd1; cyc("acc_w1_pre", 1, 1'b1, 2'd1, 1'b0);
      upd_en = 1'b0;                 cyc("acc_w1",     1, 1'b1, 2'd3, 1'b0);
      rd_idx = 5'd6;                 cyc("set6_untouched", 1, 1'b1, 2'd0, 1'b0);

      // Invalid-way preference over tree victim 3.
      rd_idx = 5'd5;
      valid_vec = 4'b1010; cyc("inv_1010", 1, 1'b1, 2'd0, 1'b1);
      valid_vec = 4'b1011; cyc("inv_1011", 1, 1'b1, 2'd2, 1'b1);
      valid_vec = 4'b0111; cyc("inv_0111", 1, 1'b1, 2'd3, 1'b1);
      valid_vec = 4'hF;    cyc("tree_back", 1, 1'b1, 2'd3, 1'b0);

      // Same set looked up and updated in one cycle: no forwarding.
      rd_idx = 5'd9; upd_idx = 5'd9; upd_way = 2'd0; upd_en = 1'b1;
      cyc("same_cycle", 1, 1'b1, 2'd0, 1'b0);
      upd_en = 1'b0;
      cyc("same_next", 1, 1'b1, 2'd2, 1'b0);

      // Reset at walk cycle 10 restarts the walk; updates during it are dropped.
      rst = 1'b1; idle();
      rst = 1'b0; repeat (10) idle();
      rst = 1'b1; idle();
      rst = 1'b0;
      upd_en = 1'b1; upd_idx = 5'd3; upd_way = 2'd0; valid_vec = 4'h0;
      for (int k = 0; k < 32; k++) cyc("rewalk", 1, 1'b0, 2'd0, 1'b0);
      upd_en = 1'b0; valid_vec = 4'hF;
      rd_idx = 5'd3; cyc("dropped_upd", 1, 1'b1, 2'd0, 1'b0);
      rd_idx = 5'd9; cyc("recleared", 1, 1'b1, 2'd0, 1'b0);

      // Two-way build: single-bit legacy behaviour.
      rd_idx2 = 2'd1; upd_idx2 = 2'd1; valid2 = 2'b11;
      cyc("w2_cleared", 2, 1'b1, 2'd0, 1'b0);
      upd_en2 = 1'b1; upd_way2 = 1'b0; cyc("w2_acc0_pre", 2, 1'b1, 2'd0, 1'b0);
      upd_en2 = 1'b0;                  cyc("w2_acc0",     2, 1'b1, 2'd1, 1'b0);
      upd_en2 = 1'b1; upd_way2 = 1'b1; cyc("w2_acc1_pre", 2, 1'b1, 2'd1, 1'b0);
      upd_en2 = 1'b0;                  cyc("w2_acc1",     2, 1'b1, 2'd0, 1'b0);
      valid2 = 2'b10; cyc("w2_inv0", 2, 1'b1, 2'd0, 1'b1);
      valid2 = 2'b01; cyc("w2_inv1", 2, 1'b1, 2'd1, 1'b1);

      idle();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/plru_mem.md
Name: plru_mem

Overview:
- Parametrised per-set replacement-state memory for an N-way set-associative data cache; successor to the single-bit 2-way LRU array.
- Stores tree pseudo-LRU (PLRU) bits per set and combinationally reports the victim way for the set being looked up, preferring invalid ways.
- Updates the set's PLRU bits when the cache controller reports a completed access.
- Clears every set through a multi-cycle walk after reset, with a ready flag back to the controller.

Parameters:
- NUM_SETS, 32, number of sets; power of 2, ≥2.
- NUM_WAYS, 4, associativity; power of 2, ≥2.
- IDX_W, $clog2(NUM_SETS), set index width (derived).
- WAY_W, $clog2(NUM_WAYS), way index width (derived).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_idx  in  IDX_W  set being looked up.
- valid_vec  in  NUM_WAYS  valid bits of rd_idx's ways; bit i = way i.
- victim_way  out  WAY_W  way to replace in set rd_idx.
- victim_inv  out  1  1 when victim_way was chosen because that way is invalid.
- upd_en  in  1  access completed; update the PLRU bits of upd_idx.
- upd_idx  in  IDX_W  set accessed.
- upd_way  in  WAY_W  way accessed (hit way or filled way).
- ready  out  1  clear walk finished; updates accepted.

Behaviour:
- Storage: NUM_SETS entries of NUM_WAYS-1 bits, held in flops or an array with no initial block. Contents are defined only by the clear walk.
- Tree encoding:
  - Heap order: node 0 is the root; node n has children 2n+1 (left, lower ways) and 2n+2 (right, upper ways).
  - Node bit 0 = victim lies in the left subtree; 1 = right subtree.
  - Leaf reached = way number. The path bits, read MSB first, equal the way index.
- Victim selection (combinational, zero latency):
  - If valid_vec has any 0: victim_way = lowest-index invalid way, victim_inv = 1.
  - Otherwise: walk the tree of entry rd_idx from the root, victim_inv = 0.
- Update: on an edge with upd_en=1 and ready=1, every node on the path to upd_way is set to point away from it.
  - upd_way in the left subtree of a node → that node's bit = 1; in the right subtree → 0.
  - Nodes off the path are unchanged.
  - NUM_WAYS=2 reduces to the previous behaviour: access way 0 → bit = 1 → victim way 1.
- Same-cycle update and lookup of the same set: no forwarding. victim_way reflects the pre-update bits; the new bits are visible the cycle after the edge.
- FSM states: CLEAR, RUN.
  - rst=1 at an edge → state CLEAR, clear counter = 0 (takes priority over everything, including mid-walk; the walk restarts at 0).
  - In CLEAR: each edge writes all-zero to entry[counter] and increments the counter.
  - When the edge writes entry NUM_SETS-1 → state RUN. The walk takes exactly NUM_SETS cycles after reset deasserts.
  - RUN is held until the next rst.
- ready: 0 during reset and CLEAR, 1 in RUN. It rises on the edge that writes the last entry.
- While ready=0:
  - upd_en is ignored (dropped, not queued).
  - victim_way = 0, victim_inv = 0, regardless of valid_vec.
- Out-of-range inputs: none possible, since the widths are exact.
- Reset values: state = CLEAR, counter = 0, ready = 0, victim_way = 0, victim_inv = 0.

Decomposition:
- Package plru_pkg holds:
  - the state enum type (CLEAR, RUN);
  - function plru_victim(bits) → way;
  - function plru_update(bits, way) → bits;
  - function first_invalid(valid_vec) → {found, way}.
  - All functions are parametrised through NUM_WAYS localparam arguments or a parameterised class.
- One sub-module is natural: plru_clear_ctrl, holding the FSM, counter and ready, and emitting a clear-write enable and index.
- Storage, victim mux and update datapath stay in plru_mem.

Test Plan:
- Clear walk: NUM_WAYS=4, NUM_SETS=32; rst high 2 cycles, then low → ready=0 for exactly 32 edges then 1. After that, with valid_vec=4'hF, victim_way=0 for all 32 sets.
- PLRU sequence, set 5, valid_vec=4'hF:
  - access way 0 → next-cycle victim 2 (bits 011);
  - access way 2 → victim 1;
  - access way 1 → victim 3;
  - set 6 still reports 0.
- Invalid preference: set 5 bits give victim 3, valid_vec=4'b1010 → victim_way=0, victim_inv=1. valid_vec=4'b1011 → victim_way=2, victim_inv=1.
- Same-set same-cycle: upd_en=1, upd_idx=rd_idx=9, upd_way=0 from the cleared state → victim_way=0 that cycle, 2 the next cycle.
- Reset mid-walk and dropped updates: assert rst at walk cycle 10 → ready stays 0 for 32 further cycles. upd_en=1 (set 3, way 0) during the walk → set 3 victim still 0 after ready.
- NUM_WAYS=2 build: access way 0 → victim 1; access way 1 → victim 0 (matches the legacy single-bit behaviour).
